node_out_arb: RTL and testbench

- Per-output-port arbiter and output register for a mesh node.
- Shares one output channel between N requesters: the 7 crossbar lanes plus local injection.
- Selection is QoS-priority then round-robin, with a starvation guard that forces a low-QoS grant after STARVE_MAX consecutive high-QoS grants.
- One-entry output register drives the downstream link, or pkt_out for the local port; full throughput under continuous backpressure release.

---
 rtl/node_out_arb.sv | 139 +++++++++++++
 tb/tb_node_out_arb.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/node_out_arb.sv
// Output-port arbiter for a mesh node: QoS-priority round-robin across N requesters
// with a starvation guard, feeding a one-entry output register.
//
// state    | meaning
// ---------+-------------------------------------------------------------
// NORMAL   | high-QoS requests win whenever present
// FORCE_LO | low-QoS requests win until one is granted or none is pending
module node_out_arb #(
  parameter int N          = 8,
  parameter int TYPE_W     = 2,
  parameter int ID_W       = 6,
  parameter int FLIT_W     = 8,
  parameter int STARVE_MAX = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [N-1:0]          req_vld,
  input  logic [N-1:0]          req_qos,
  input  logic [N*TYPE_W-1:0]   req_type,
  input  logic [N*ID_W-1:0]     req_src,
  input  logic [N*ID_W-1:0]     req_tgt,
  input  logic [N*FLIT_W-1:0]   req_data,
  output logic [N-1:0]          req_rdy,
  output logic                  out_vld,
  output logic                  out_qos,
  output logic [TYPE_W-1:0]     out_type,
  output logic [ID_W-1:0]       out_src,
  output logic [ID_W-1:0]       out_tgt,
  output logic [FLIT_W-1:0]     out_data,
  input  logic                  out_rdy,
  output logic [$clog2(N)-1:0]  grant_idx,
  output logic                  force_lo
);

  localparam int IDX_W = $clog2(N);
  localparam logic [3:0] SMAX = 4'(STARVE_MAX);

  typedef enum logic {NORMAL, FORCE_LO} state_t;

  state_t           r_state, w_state_nxt;
  logic [3:0]       r_starve, w_starve_nxt;
  logic [IDX_W-1:0] r_rr_hi, r_rr_lo;

  logic [N-1:0]     w_hi, w_lo, w_elig;
  logic             w_use_hi, w_load, w_up_found;
  logic [IDX_W-1:0] w_ptr, w_gnt, w_gnt_any, w_gnt_up, w_rr_next;

  assign w_hi     = req_vld & req_qos;
  assign w_lo     = req_vld & ~req_qos;
  assign w_use_hi = (r_state == NORMAL) ? (|w_hi) : ~(|w_lo);
  assign w_elig   = w_use_hi ? w_hi : w_lo;
  assign w_ptr    = w_use_hi ? r_rr_hi : r_rr_lo;
  assign w_load   = !rst && (!out_vld || out_rdy) && (|w_elig);
  assign force_lo = (r_state == FORCE_LO);

  // Downward scan leaves the lowest eligible index overall and the lowest at/above the pointer.
  always_comb begin
    w_gnt_any  = '0;
    w_gnt_up   = '0;
    w_up_found = 1'b0;
    for (int i = N - 1; i >= 0; i--) begin
      if (w_elig[i]) begin
        w_gnt_any = IDX_W'(i);
        if (IDX_W'(i) >= w_ptr) begin
          w_gnt_up   = IDX_W'(i);
          w_up_found = 1'b1;
        end
      end
    end
    w_gnt = w_up_found ? w_gnt_up : w_gnt_any;
  end

  assign w_rr_next = (w_gnt == IDX_W'(N - 1)) ? '0 : w_gnt + 1'b1;

  always_comb begin
    req_rdy = '0;
    if (w_load) req_rdy[w_gnt] = 1'b1;
  end

  always_comb begin
    w_starve_nxt = r_starve;
    if (w_load) begin
      if (w_use_hi && (|w_lo))
        w_starve_nxt = (r_starve >= SMAX) ? SMAX : r_starve + 4'd1;
      else
        w_starve_nxt = '0;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      NORMAL:
        if (w_load && w_use_hi && (|w_lo) && (w_starve_nxt == SMAX))
          w_state_nxt = FORCE_LO;
      FORCE_LO:
        if ((w_load && !w_use_hi) || !(|w_lo))
          w_state_nxt = NORMAL;
      default:
        w_state_nxt = NORMAL;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) r_state <= NORMAL;
    else     r_state <= w_state_nxt;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_starve  <= '0;
      r_rr_hi   <= '0;
      r_rr_lo   <= '0;
      out_vld   <= 1'b0;
      out_qos   <= 1'b0;
      out_type  <= '0;
      out_src   <= '0;
      out_tgt   <= '0;
      out_data  <= '0;
      grant_idx <= '0;
    end else begin
      r_starve <= w_starve_nxt;
      if (w_load) begin
        if (w_use_hi) r_rr_hi <= w_rr_next;
        else          r_rr_lo <= w_rr_next;
        out_vld   <= 1'b1;
        out_qos   <= req_qos[w_gnt];
        out_type  <= req_type[w_gnt*TYPE_W +: TYPE_W];
        out_src   <= req_src[w_gnt*ID_W +: ID_W];
        out_tgt   <= req_tgt[w_gnt*ID_W +: ID_W];
        out_data  <= req_data[w_gnt*FLIT_W +: FLIT_W];
        grant_idx <= w_gnt;
      end else if (out_rdy) begin
        out_vld <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_node_out_arb.sv
// Bench for node_out_arb: directed vector table, hand sequences and a randomized
// run, all compared against an integer-level reference model.
module tb_node_out_arb;
  localparam int N = 8, TYPE_W = 2, ID_W = 6, FLIT_W = 8, STARVE_MAX = 4;

  logic clk, rst, out_rdy;
  logic [N-1:0] req_vld, req_qos, req_rdy;
  logic [N*TYPE_W-1:0] req_type;
  logic [N*ID_W-1:0] req_src, req_tgt;
  logic [N*FLIT_W-1:0] req_data;
  logic out_vld, out_qos, force_lo;
  logic [TYPE_W-1:0] out_type;
  logic [ID_W-1:0] out_src, out_tgt;
  logic [FLIT_W-1:0] out_data;
  logic [2:0] grant_idx;

  logic [TYPE_W-1:0] p_type [N];
  logic [ID_W-1:0]   p_src  [N];
  logic [ID_W-1:0]   p_tgt  [N];
  logic [FLIT_W-1:0] p_data [N];

  node_out_arb #(.N(N), .TYPE_W(TYPE_W), .ID_W(ID_W), .FLIT_W(FLIT_W), .STARVE_MAX(STARVE_MAX)) dut (
    .clk(clk), .rst(rst), .req_vld(req_vld), .req_qos(req_qos), .req_type(req_type),
    .req_src(req_src), .req_tgt(req_tgt), .req_data(req_data), .req_rdy(req_rdy),
    .out_vld(out_vld), .out_qos(out_qos), .out_type(out_type), .out_src(out_src),
    .out_tgt(out_tgt), .out_data(out_data), .out_rdy(out_rdy), .grant_idx(grant_idx),
    .force_lo(force_lo));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always_comb begin
    req_type = '0; req_src = '0; req_tgt = '0; req_data = '0;
    for (int i = 0; i < N; i++) begin
      req_type[i*TYPE_W +: TYPE_W] = p_type[i];
      req_src[i*ID_W +: ID_W]      = p_src[i];
      req_tgt[i*ID_W +: ID_W]      = p_tgt[i];
      req_data[i*FLIT_W +: FLIT_W] = p_data[i];
    end
  end

  int n_chk = 0, n_fail = 0;

  // Reference model state
  int m_rr_hi = 0, m_rr_lo = 0, m_cnt = 0, m_gidx = 0;
  bit m_force = 0, m_out_vld = 0, m_qos = 0;
  logic [TYPE_W-1:0] m_type = '0;
  logic [ID_W-1:0]   m_src = '0, m_tgt = '0;
  logic [FLIT_W-1:0] m_data = '0;

  logic [N-1:0] last_rdy, last_exp_rdy;

  typedef struct {
    bit r; logic [N-1:0] vld; logic [N-1:0] qos; bit ordy;
    logic [N-1:0] exp_rdy; bit exp_ovld; logic [2:0] exp_gidx; bit exp_force;
  } vec_t;

  vec_t tbl[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // One clock cycle: drive, check req_rdy mid-cycle, clock, advance model, check outputs.
  task automatic apply(input bit r, input logic [N-1:0] v, input logic [N-1:0] q, input bit ordy);
    logic [N-1:0] hi, lo, elig, exp_rdy;
    bit use_hi, load, f0;
    int ptr, g, idx, newcnt;
    rst = r; req_vld = v; req_qos = q; out_rdy = ordy;
    hi = v & q;
    lo = v & ~q;
    use_hi = m_force ? (lo == 0) : (hi != 0);
    elig = use_hi ? hi : lo;
    ptr = use_hi ? m_rr_hi : m_rr_lo;
    g = -1;
    for (int k = 0; k < N; k++) begin
      idx = (ptr + k) % N;
      if (g < 0 && elig[idx]) g = idx;
    end
    load = !r && (!m_out_vld || ordy) && (g >= 0);
    exp_rdy = '0;
    if (load) exp_rdy[g] = 1'b1;
    @(negedge clk);
    last_rdy = req_rdy;
    last_exp_rdy = exp_rdy;
    chk("model_req_rdy", 32'(req_rdy), 32'(exp_rdy));
    @(posedge clk);
    #1;
    if (r) begin
      m_rr_hi = 0; m_rr_lo = 0; m_cnt = 0; m_force = 0; m_gidx = 0;
      m_out_vld = 0; m_qos = 0; m_type = '0; m_src = '0; m_tgt = '0; m_data = '0;
    end else begin
      f0 = m_force;
      newcnt = m_cnt;
      if (load) begin
        if (use_hi && lo != 0) newcnt = (m_cnt + 1 > STARVE_MAX) ? STARVE_MAX : m_cnt + 1;
        else newcnt = 0;
      end
      if (!f0) m_force = load && use_hi && (lo != 0) && (newcnt == STARVE_MAX);
      else     m_force = !((load && !use_hi) || lo == 0);
      m_cnt = newcnt;
      if (load) begin
        if (use_hi) m_rr_hi = (g + 1) % N;
        else        m_rr_lo = (g + 1) % N;
        m_out_vld = 1; m_qos = q[g]; m_type = p_type[g]; m_src = p_src[g];
        m_tgt = p_tgt[g]; m_data = p_data[g]; m_gidx = g;
      end else if (ordy) begin
        m_out_vld = 0;
      end
    end
    chk("model_out_vld", 32'(out_vld), 32'(m_out_vld));
    chk("model_out_qos", 32'(out_qos), 32'(m_qos));
    chk("model_out_type", 32'(out_type), 32'(m_type));
    chk("model_out_src", 32'(out_src), 32'(m_src));
    chk("model_out_tgt", 32'(out_tgt), 32'(m_tgt));
    chk("model_out_data", 32'(out_data), 32'(m_data));
    chk("model_grant_idx", 32'(grant_idx), 32'(m_gidx));
    chk("model_force_lo", 32'(force_lo), 32'(m_force));
  endtask

  task automatic run_vec(input vec_t t, input string tag);
    apply(t.r, t.vld, t.qos, t.ordy);
    chk({tag, "_rdy"}, 32'(last_rdy), 32'(t.exp_rdy));
    chk({tag, "_ovld"}, 32'(out_vld), 32'(t.exp_ovld));
    chk({tag, "_gidx"}, 32'(grant_idx), 32'(t.exp_gidx));
    chk({tag, "_force"}, 32'(force_lo), 32'(t.exp_force));
  endtask

  initial begin
    logic [N-1:0] cur_vld, cur_qos;
    bit r, ordy;
    for (int i = 0; i < N; i++) begin
      p_type[i] = 2'(i); p_src[i] = 6'(i); p_tgt[i] = 6'(8'h10 + i); p_data[i] = 8'(8'hC0 + i);
    end
    p_data[3] = 8'hA5;
    p_tgt[3]  = 6'h12;

    // Reset with everyone requesting, then low-QoS round robin with a 3-cycle stall
    tbl.push_back('{1'b1, 8'hFF, 8'h00, 1'b1, 8'h00, 1'b0, 3'd0, 1'b0});
    tbl.push_back('{1'b1, 8'hFF, 8'h00, 1'b1, 8'h00, 1'b0, 3'd0, 1'b0});
    for (int i = 0; i < N; i++)
      tbl.push_back('{1'b0, 8'hFF, 8'h00, 1'b1, 8'(1 << i), 1'b1, 3'(i), 1'b0});
    tbl.push_back('{1'b0, 8'hFF, 8'h00, 1'b1, 8'h01, 1'b1, 3'd0, 1'b0});
    for (int i = 0; i < 3; i++)
      tbl.push_back('{1'b0, 8'hFF, 8'h00, 1'b0, 8'h00, 1'b1, 3'd0, 1'b0});
    tbl.push_back('{1'b0, 8'hFF, 8'h00, 1'b1, 8'h02, 1'b1, 3'd1, 1'b0});
    tbl.push_back('{1'b0, 8'hFF, 8'h00, 1'b1, 8'h04, 1'b1, 3'd2, 1'b0});
    // Lone high-QoS requester 6: never forces
    for (int i = 0; i < 3; i++)
      tbl.push_back('{1'b0, 8'h40, 8'h40, 1'b1, 8'h40, 1'b1, 3'd6, 1'b0});
    // High 1,5 vs low 2: 1,5,1,5 then forced 2, twice
    for (int rep = 0; rep < 2; rep++) begin
      tbl.push_back('{1'b0, 8'h26, 8'h22, 1'b1, 8'h02, 1'b1, 3'd1, 1'b0});
      tbl.push_back('{1'b0, 8'h26, 8'h22, 1'b1, 8'h20, 1'b1, 3'd5, 1'b0});
      tbl.push_back('{1'b0, 8'h26, 8'h22, 1'b1, 8'h02, 1'b1, 3'd1, 1'b0});
      tbl.push_back('{1'b0, 8'h26, 8'h22, 1'b1, 8'h20, 1'b1, 3'd5, 1'b1});
      tbl.push_back('{1'b0, 8'h26, 8'h22, 1'b1, 8'h04, 1'b1, 3'd2, 1'b0});
    end

    for (int i = 0; i < tbl.size(); i++) run_vec(tbl[i], "tbl");

    // Single requester 3 payload pass-through, then drain
    run_vec('{1'b0, 8'h08, 8'h00, 1'b1, 8'h08, 1'b1, 3'd3, 1'b0}, "single3");
    chk("single3_data", 32'(out_data), 32'h0000_00A5);
    chk("single3_tgt", 32'(out_tgt), 32'h0000_0012);
    run_vec('{1'b0, 8'h00, 8'h00, 1'b1, 8'h00, 1'b0, 3'd3, 1'b0}, "drain");

    // Mid-stream reset: pending packet dropped, pointers and starvation count cleared
    run_vec('{1'b0, 8'h15, 8'h14, 1'b0, 8'h04, 1'b1, 3'd2, 1'b0}, "pre_rst");
    run_vec('{1'b0, 8'h15, 8'h14, 1'b0, 8'h00, 1'b1, 3'd2, 1'b0}, "hold");
    run_vec('{1'b1, 8'h15, 8'h14, 1'b0, 8'h00, 1'b0, 3'd0, 1'b0}, "mid_rst");
    run_vec('{1'b0, 8'h15, 8'h14, 1'b1, 8'h04, 1'b1, 3'd2, 1'b0}, "post_rst1");
    run_vec('{1'b0, 8'h15, 8'h14, 1'b1, 8'h10, 1'b1, 3'd4, 1'b0}, "post_rst2");
    run_vec('{1'b0, 8'h15, 8'h14, 1'b1, 8'h04, 1'b1, 3'd2, 1'b0}, "post_rst3");
    run_vec('{1'b0, 8'h15, 8'h14, 1'b1, 8'h10, 1'b1, 3'd4, 1'b1}, "post_rst4");
    run_vec('{1'b0, 8'h15, 8'h14, 1'b1, 8'h01, 1'b1, 3'd0, 1'b0}, "post_rst5");

    // Randomized traffic; a requester holds vld/qos/payload until accepted
    cur_vld = '0;
    cur_qos = '0;
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < N; i++) begin
        if (!(cur_vld[i] && !last_exp_rdy[i])) begin
          cur_vld[i] = ($urandom_range(0, 9) < 6);
          cur_qos[i] = ($urandom_range(0, 9) < 5);
          p_type[i] = 2'($urandom);
          p_src[i]  = 6'($urandom);
          p_tgt[i]  = 6'($urandom);
          p_data[i] = 8'($urandom);
        end
      end
      r = ($urandom_range(0, 49) == 0);
      ordy = ($urandom_range(0, 9) < 7);
      apply(r, cur_vld, cur_qos, ordy);
      if (r) cur_vld = '0;
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
